// File: rtl/dither_pkg.sv
// Shared definitions for the ordered-dither pipeline: mode encodings, the
// default 4x4 Bayer offset table and the saturate/quantise helper.
package dither_pkg;

    typedef enum logic [1:0] {
        DM_BYPASS   = 2'd0,
        DM_ORDERED  = 2'd1,
        DM_TEMPORAL = 2'd2,
        DM_RESERVED = 2'd3
    } dither_mode_t;

    // Bayer rank * 16 - 128, row-major {y, x}; a flat mid-grey lights half of each tile.
    localparam int BAYER4_OFF [16] = '{
        -128,    0,  -96,   32,
          64,  -64,   96,  -32,
         -80,   48, -112,   16,
         112,  -16,   80,  -48
    };

    function automatic logic [3:0] sat_quant(input int sum, input int in_bits, input int out_bits);
        int max_v;
        int sat;
        max_v = (1 << in_bits) - 1;
        if (sum < 0)
            sat = 0;
        else if (sum > max_v)
            sat = max_v;
        else
            sat = sum;
        sat = sat >> (in_bits - out_bits);
        return sat[3:0];
    endfunction

endpackage

// File: rtl/dither_lane.sv
// One pixel lane: stage 1 registers the biased sum, stage 2 registers the
// saturated and quantised result. Both stages advance on the shared enable.
module dither_lane
    import dither_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int BIAS     = 10,
    parameter int OW       = IN_BITS - OUT_BITS + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                adv,
    input  logic                bypass,
    input  logic [IN_BITS-1:0]  value,
    input  logic [OW-1:0]       off,
    output logic [OUT_BITS-1:0] q
);

    localparam int SW = IN_BITS + 2;

    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_r;

    always_comb begin
        sum_d = $signed({2'b00, value});
        if (!bypass)
            sum_d = sum_d + SW'(BIAS) + SW'($signed(off));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sum_r <= '0;
            q     <= '0;
        end else if (adv) begin
            sum_r <= sum_d;
            q     <= OUT_BITS'(sat_quant(int'(sum_r), IN_BITS, OUT_BITS));
        end
    end

endmodule

// File: rtl/ordered_dither_pipe.sv
// Ordered-dither stage: tracks x/y/frame position, holds shadow and active
// threshold matrices, and drives LANES dither lanes behind a global stall.
module ordered_dither_pipe
    import dither_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int MLOG2    = 2,
    parameter int BIAS     = 10,
    parameter int OW       = IN_BITS - OUT_BITS + 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sol,
    input  logic                      in_sof,
    input  logic [LANES*IN_BITS-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_BITS-1:0] out_data,
    input  logic                      cfg_we,
    input  logic [2*MLOG2-1:0]        cfg_addr,
    input  logic [OW-1:0]             cfg_wdata
);

    localparam int MSZ = 1 << (2 * MLOG2);
    localparam int XW  = 16;

    logic [OW-1:0]      shadow_m [MSZ];
    logic [OW-1:0]      active_m [MSZ];
    logic               s1_valid;
    logic               s2_valid;
    logic [XW-1:0]      xcnt;
    logic [XW-1:0]      ycnt;
    logic [2*MLOG2-1:0] fcnt;

    logic               accept;
    logic               sol_eff;
    logic               bypass;
    logic               temporal;
    logic [XW-1:0]      xpos;
    logic [XW-1:0]      ypos;
    logic [2*MLOG2-1:0] fpos;
    logic [MLOG2-1:0]   mx_rot;
    logic [MLOG2-1:0]   my_rot;

    assign in_ready  = !s2_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // The sof beat already belongs to the new frame: it sees the reset
    // position, the incremented frame count and the freshly copied matrix.
    always_comb begin
        sol_eff  = in_sol || in_sof;
        bypass   = (mode == DM_BYPASS);
        temporal = (mode == DM_TEMPORAL);
        xpos     = sol_eff ? '0 : xcnt;
        if (in_sof)
            ypos = '0;
        else if (in_sol)
            ypos = ycnt + 1'b1;
        else
            ypos = ycnt;
        fpos     = in_sof ? fcnt + 1'b1 : fcnt;
        mx_rot   = temporal ? fpos[MLOG2-1:0] : '0;
        my_rot   = temporal ? fpos[2*MLOG2-1:MLOG2] : '0;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [MLOG2-1:0] mx;
        logic [MLOG2-1:0] my;
        logic [OW-1:0]    off;

        assign mx  = MLOG2'(xpos + XW'(i)) + mx_rot;
        assign my  = MLOG2'(ypos) + my_rot;
        assign off = in_sof ? shadow_m[{my, mx}] : active_m[{my, mx}];

        dither_lane #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS),
            .BIAS     (BIAS),
            .OW       (OW)
        ) u_lane (
            .clk    (clk),
            .rstn   (rstn),
            .adv    (in_ready),
            .bypass (bypass),
            .value  (in_data[(LANES-1-i)*IN_BITS +: IN_BITS]),
            .off    (off),
            .q      (out_data[(LANES-1-i)*OUT_BITS +: OUT_BITS])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            xcnt     <= '0;
            ycnt     <= '0;
            fcnt     <= '0;
            for (int k = 0; k < MSZ; k++) begin
                shadow_m[k] <= '0;
                active_m[k] <= '0;
            end
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                s2_valid <= s1_valid;
            end
            if (accept) begin
                xcnt <= xpos + XW'(LANES);
                ycnt <= ypos;
                fcnt <= fpos;
                if (in_sof)
                    active_m <= shadow_m;
            end
            // Copy above reads the pre-write shadow, deferring a same-cycle write one frame.
            if (cfg_we)
                shadow_m[cfg_addr] <= cfg_wdata;
        end
    end

endmodule

// File: tb/tb_ordered_dither_pipe.sv
// Scoreboard bench for ordered_dither_pipe: driver pushes reference-model
// results on each accepted beat, a monitor pops them on each output transfer.
module tb_ordered_dither_pipe;
    import dither_pkg::*;

    localparam int BIAS = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sol = 1'b0;
    logic        in_sof = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_data;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_wdata = '0;

    ordered_dither_pipe dut (
        .clk       (clk),
        .rstn      (rstn),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sol    (in_sol),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [3:0] exp_q[$];
    int         sh_m[16];
    int         ac_m[16];
    int         m_x = 0;
    int         m_y = 0;
    int         m_f = 0;
    int         rdy_mode = 0;
    int         ones_cnt = 0;
    logic [3:0] held;

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Reference: position/frame bookkeeping and per-pixel integer arithmetic.
    function automatic logic [3:0] model_beat(int md, bit sol, bit sof, logic [31:0] d);
        int xpos, rx, ry, v, s, idx;
        logic [3:0] r;
        xpos = (sol || sof) ? 0 : m_x;
        if (sof) m_y = 0;
        else if (sol) m_y = m_y + 1;
        if (sof) m_f = (m_f + 1) % 16;
        rx = (md == 2) ? m_f % 4 : 0;
        ry = (md == 2) ? m_f / 4 : 0;
        for (int i = 0; i < 4; i++) begin
            v = int'(d[(3-i)*8 +: 8]);
            if (md == 0) begin
                s = v;
            end else begin
                idx = ((m_y + ry) % 4) * 4 + ((xpos + i + rx) % 4);
                s = v + BIAS + ac_m[idx];
            end
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            r[3-i] = (s >= 128);
        end
        m_x = xpos + 4;
        return r;
    endfunction

    task automatic idle();
        in_valid = 1'b0;
        in_sol = 1'b0;
        in_sof = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic send_beat(int md, bit sol, bit sof, logic [31:0] d,
                             bit wr = 1'b0, int wa = 0, int wd = 0);
        bit acc;
        int guard = 0;
        mode = md[1:0]; in_sol = sol; in_sof = sof; in_data = d; in_valid = 1'b1;
        cfg_we = wr; cfg_addr = wa[3:0]; cfg_wdata = wd[7:0];
        forever begin
            #2;
            acc = in_ready;
            if (acc) begin
                if (sof) ac_m = sh_m;
                exp_q.push_back(model_beat(md, sol, sof, d));
            end
            if (wr) sh_m[wa] = wd;
            @(negedge clk);
            guard++;
            if (acc) break;
            if (guard > 300) begin
                n_checks++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
                break;
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write(int a, int d);
        in_valid = 1'b0; cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_wdata = d[7:0];
        sh_m[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_bayer();
        for (int k = 0; k < 16; k++) cfg_write(k, BAYER4_OFF[k]);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        #2;
        check("drain_empty", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        @(negedge clk);
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin sh_m[k] = 0; ac_m[k] = 0; end
        m_x = 0; m_y = 0; m_f = 0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial forever begin
        @(negedge clk);
        out_ready = (rdy_mode == 0) ? 1'b1 :
                    (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_beat: got %h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", int'(out_data), int'(e));
                    ones_cnt += $countones(out_data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Bypass truncation and two-cycle latency.
        send_beat(0, 1, 1, 32'hFF807F00);
        idle();
        #2 check("lat_cycle1_valid", int'(out_valid), 0);
        @(negedge clk);
        #2 check("lat_cycle2_valid", int'(out_valid), 1);
        @(negedge clk);
        send_beat(1, 1, 0, 32'h80808080);
        idle();
        drain();

        // Bayer over a flat 16x4 mid-grey frame: 8 ones per tile.
        load_bayer();
        ones_cnt = 0;
        for (int ln = 0; ln < 4; ln++)
            for (int b = 0; b < 4; b++)
                send_beat(1, b == 0, ln == 0 && b == 0, 32'h80808080);
        idle();
        drain();
        check("bayer_ones", ones_cnt, 32);

        // Saturation at both extremes.
        for (int k = 0; k < 16; k++) cfg_write(k, 127);
        send_beat(1, 1, 1, 32'hFFFFFFFF);
        send_beat(1, 0, 0, 32'hFFFFFFFF);
        for (int k = 0; k < 16; k++) cfg_write(k, -128);
        send_beat(1, 1, 1, 32'h00000000);
        send_beat(1, 0, 0, 32'h80808080);
        idle();
        drain();

        // Back-pressure mid-line.
        load_bayer();
        send_beat(1, 1, 1, $urandom);
        send_beat(1, 0, 0, $urandom);
        fork
            begin
                for (int b = 2; b < 8; b++) send_beat(1, b % 4 == 0, 0, $urandom);
                idle();
            end
            begin
                rdy_mode = 2;
                repeat (3) @(negedge clk);
                #2;
                held = out_data;
                for (int c = 0; c < 5; c++) begin
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_out_valid", int'(out_valid), 1);
                    check("stall_out_data", int'(out_data), int'(held));
                    @(negedge clk);
                    #2;
                end
                rdy_mode = 0;
            end
        join
        drain();

        // Mid-frame write defers to next sof; write in the sof cycle defers another frame.
        send_beat(1, 1, 1, 32'h80808080);
        cfg_write(0, 100);
        send_beat(1, 1, 0, 32'h80808080);
        send_beat(1, 1, 0, 32'h80808080);
        send_beat(1, 1, 0, 32'h80808080);
        send_beat(1, 1, 0, 32'h80808080);
        send_beat(1, 1, 1, 32'h80808080, 1'b1, 0, -128);
        send_beat(1, 1, 0, 32'h80808080);
        send_beat(1, 1, 1, 32'h80808080);
        idle();
        drain();

        // Randomised traffic with random modes, cfg writes and back-pressure.
        rdy_mode = 1;
        for (int f = 0; f < 3; f++)
            for (int ln = 0; ln < 3; ln++)
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 5) == 0)
                        cfg_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
                    send_beat(int'($urandom_range(0, 3)), b == 0, ln == 0 && b == 0, $urandom,
                              (ln == 0 && b == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                              int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
                end
        idle();
        rdy_mode = 0;
        drain();

        // Temporal rotation over four frames.
        load_bayer();
        for (int f = 0; f < 4; f++)
            for (int ln = 0; ln < 4; ln++)
                send_beat(2, 1, ln == 0, 32'h80808080);
        idle();
        drain();

        // Reset mid-frame, then confirm cleared matrices and restarted counters.
        send_beat(2, 1, 1, 32'h80808080);
        send_beat(2, 1, 0, 32'h80808080);
        do_reset();
        send_beat(1, 1, 0, 32'h80808080);
        idle();
        load_bayer();
        send_beat(2, 1, 1, 32'h80808080);
        send_beat(2, 1, 0, 32'h80808080);
        send_beat(2, 0, 0, 32'h80808080);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ordered_dither_pipe.md
Name: ordered_dither_pipe

Overview:
- Parametrised ordered-dither stage that quantises LANES pixels per beat from IN_BITS to OUT_BITS, using a runtime-programmable 2^MLOG2 x 2^MLOG2 threshold matrix.
- Tracks x/y position internally from start-of-line/start-of-frame markers and applies optional per-frame temporal matrix rotation.
- Uses valid/ready flow control; sits between the pixel processing pipeline and the EPD waveform/LUT stage.

Parameters:
- LANES, 4, pixels per beat; lane i sits at x = xbase + i.
- IN_BITS, 8, input pixel width.
- OUT_BITS, 1, output pixel width; legal range 1..4, and must be less than IN_BITS.
- MLOG2, 2, log2 of the matrix edge (matrix is 4x4 at the default).
- BIAS, 10, unsigned constant added before the offset.
- OW, IN_BITS-OUT_BITS+1, width of each signed matrix entry.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- mode  in  2  0 = bypass (truncate), 1 = ordered, 2 = ordered+temporal, 3 = reserved (behaves as 1); sampled per accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_sol  in  1  beat is the first of a line.
- in_sof  in  1  beat is the first of a frame; implies sol.
- in_data  in  LANES*IN_BITS  pixels; lane 0 in the MSBs.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*OUT_BITS  quantised pixels; lane 0 in the MSBs.
- cfg_we  in  1  matrix write strobe.
- cfg_addr  in  2*MLOG2  matrix entry index, {y, x}.
- cfg_wdata  in  OW  signed offset.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - out_valid=0, out_data=0.
  - Both pipeline stages empty; x, y and frame counters = 0.
  - Shadow and active matrices = all zero.
  - Reset mid-frame discards all in-flight beats.
- Flow control:
  - in_ready = !s2_valid || out_ready, a global stall with no combinational path from in_valid.
  - When stalled, all stage registers hold and out_data stays stable.
- Latency: 2 cycles from an accepted beat to out_valid with no stall. Stage 1 registers the sums; stage 2 registers saturate+quantise.
- Position tracking:
  - On an accepted beat, xpos = sol ? 0 : xcnt.
  - After the beat, xcnt = xpos + LANES.
  - y: sof sets it to 0; sol without sof increments it.
  - fcnt (MLOG2*2 bits): increments on each accepted sof beat; wraps naturally.
- Matrix index:
  - Modes 0/1: mx = (xpos+i) mod 2^MLOG2, my = y mod 2^MLOG2.
  - Mode 2: mx and my are each offset by fcnt fields (mx += fcnt[MLOG2-1:0], my += fcnt[2*MLOG2-1:MLOG2]) before the mod.
- Arithmetic, per lane:
  - s = v + BIAS + sext(off), computed in IN_BITS+2 signed bits.
  - Saturate to [0, 2^IN_BITS-1].
  - Output = top OUT_BITS of the saturated value.
  - Mode 0: off=0 and BIAS is skipped, i.e. a pure truncation of v.
- Configuration:
  - cfg_we writes the shadow matrix immediately.
  - The active matrix copies the shadow on the accepted sof beat, so changes take effect frame-aligned.
  - cfg_we and copy in the same cycle: active receives the pre-write shadow; the new entry applies at the following sof.
  - The config port is never stalled.
- Back-pressure does not corrupt the counters: they update only on accepted beats.

Decomposition:
- Shared package dither_pkg holds:
  - mode encodings (DM_BYPASS, DM_ORDERED, DM_TEMPORAL);
  - the default 4x4 Bayer offset constant, used by firmware and benches;
  - a sat_quant function.
- One sub-module, dither_lane, instantiated LANES times. It performs the add/saturate/quantise for one pixel, taking a value and an offset.
- Counters, matrix storage and handshake stay in the top module.

Test Plan:
- Reset, then mode=0 with in_data=0xFF_80_7F_00 at OUT_BITS=1 -> out_data=4'b1100 two cycles later; out_valid held 0 during reset.
- Load the Bayer matrix, send sof, then mode=1 with a flat 0x80 frame of 16x4 pixels -> each 4x4 tile contains exactly 8 ones; the pattern repeats every 4 beats per line.
- Saturation: off=+127 with v=0xFF -> out 1 (no wrap); off=-128 with v=0x00 -> out 0.
- Hold out_ready=0 for 5 cycles mid-line -> in_ready=0 after the pipe fills, out_data stable, no beat lost or duplicated; x sequence continuous after release.
- Write entry 0 = +100 mid-frame -> output is unchanged until the next sof beat and changes at that frame; cfg_we in the sof cycle is deferred one frame.
- Mode=2 over 4 frames on a flat input -> per-pixel outputs rotate according to fcnt; assert rstn=0 mid-frame -> out_valid=0 next cycle and the counters restart from 0.
